// File: rtl/even_parity_checker.sv
// Serial receiver for start + DATA_WIDTH data bits (LSB first) + even parity + stop frames.
// Reports data, parity and framing verdicts per frame and a saturating error count.
module even_parity_checker #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  parity_ok,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  busy
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE_S   = 3'd0,
    DATA_S   = 3'd1,
    PARITY_S = 3'd2,
    STOP_S   = 3'd3,
    BREAK_S  = 3'd4
  } state_t;

  state_t                state_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  acc_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  valid_q;
  logic                  parity_ok_q;
  logic                  frame_err_q;
  logic [CNT_WIDTH-1:0]  err_count_q;
  logic                  busy_q;

  // Receive FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE_S;
      bit_cnt_q   <= '0;
      acc_q       <= 1'b0;
      shift_q     <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      parity_ok_q <= 1'b1;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE_S: begin
          if (!serial_in) begin
            state_q   <= DATA_S;
            bit_cnt_q <= '0;
            acc_q     <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        DATA_S: begin
          shift_q <= {serial_in, shift_q[DATA_WIDTH-1:1]};
          acc_q   <= acc_q ^ serial_in;
          if (bit_cnt_q == LAST_BIT) begin
            state_q   <= PARITY_S;
            bit_cnt_q <= '0;
          end else begin
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        PARITY_S: begin
          acc_q   <= acc_q ^ serial_in;
          state_q <= STOP_S;
        end
        STOP_S: begin
          data_out_q  <= shift_q;
          parity_ok_q <= ~acc_q;
          frame_err_q <= ~serial_in;
          valid_q     <= 1'b1;
          // One increment per bad frame, even if both parity and framing fail.
          if ((acc_q || !serial_in) && (err_count_q != '1))
            err_count_q <= err_count_q + CNT_WIDTH'(1);
          if (serial_in) begin
            state_q <= IDLE_S;
            busy_q  <= 1'b0;
          end else begin
            state_q <= BREAK_S;
          end
        end
        BREAK_S: begin
          if (serial_in) begin
            state_q <= IDLE_S;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE_S;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign valid     = valid_q;
  assign parity_ok = parity_ok_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_even_parity_checker.sv
// Scoreboard bench for even_parity_checker: frames are modelled on send, checked on valid.
module tb_even_parity_checker;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          serial_in;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          parity_ok;
  logic          frame_err;
  logic [CW-1:0] err_count;
  logic          busy;

  even_parity_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in),
    .data_out(data_out), .valid(valid), .parity_ok(parity_ok),
    .frame_err(frame_err), .err_count(err_count), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic          pok;
    logic          ferr;
    logic [CW-1:0] cnt;
    int            vcyc;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic          prev_valid = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: every valid pulse pops and compares one expected frame.
  always @(negedge clock) begin
    if (prev_valid && valid === 1'b1) check_eq("valid_twice", 32'(valid), 32'd0);
    if (valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("data_out",  32'(data_out),  32'(e.d));
        check_eq("parity_ok", 32'(parity_ok), 32'(e.pok));
        check_eq("frame_err", 32'(frame_err), 32'(e.ferr));
        check_eq("err_count", 32'(err_count), 32'(e.cnt));
        check_eq("valid_cyc", 32'(cyc),       32'(e.vcyc));
      end
    end
    prev_valid = (valid === 1'b1);
  end

  // Drive one bit; called at a falling edge, returns at the next falling edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    exp_t e;
    logic pok;
    pok    = ~(^d ^ par);
    e.d    = d;
    e.pok  = pok;
    e.ferr = ~stop;
    if ((!pok || !stop) && exp_cnt != '1) exp_cnt = exp_cnt + CW'(1);
    e.cnt  = exp_cnt;
    e.vcyc = cyc + 19;
    sb_q.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < int'(DW); i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_data"},  32'(data_out),  32'd0);
    check_eq({tag, "_valid"}, 32'(valid),     32'd0);
    check_eq({tag, "_pok"},   32'(parity_ok), 32'd1);
    check_eq({tag, "_ferr"},  32'(frame_err), 32'd0);
    check_eq({tag, "_cnt"},   32'(err_count), 32'd0);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  task automatic apply_reset();
    serial_in = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check_reset_state("rst");
    reset = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    serial_in = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_state("por");
    reset = 1'b0;
    repeat (2) send_bit(1'b1);

    send_frame(16'h0007, 1'b1, 1'b1);
    repeat (2) send_bit(1'b1);
    send_frame(16'h0007, 1'b0, 1'b1);
    send_bit(1'b1);
    send_frame(16'h0003, 1'b0, 1'b1);
    repeat (3) send_bit(1'b1);

    // Framing error followed by a held-low line: must stay in break.
    send_frame(16'hA5A5, 1'b0, 1'b0);
    check_eq("busy_break0", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      check_eq("busy_break", 32'(busy), 32'd1);
    end
    send_bit(1'b1);
    check_eq("busy_idle", 32'(busy), 32'd0);
    send_frame(16'h1234, 1'b1, 1'b1);
    repeat (2) send_bit(1'b1);

    send_frame(16'hFFFF, 1'b0, 1'b1);
    send_frame(16'h8001, 1'b0, 1'b1);
    repeat (2) send_bit(1'b1);

    // Reset during data bit 8 discards the partial frame.
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    check_eq("busy_mid", 32'(busy), 32'd1);
    apply_reset();
    send_frame(16'h00FF, 1'b0, 1'b1);
    repeat (2) send_bit(1'b1);

    for (int i = 0; i < 260; i++) begin
      logic [DW-1:0] d;
      d = DW'($urandom);
      send_frame(d, ^d ^ 1'b1, 1'b1);
    end
    repeat (2) send_bit(1'b1);
    check_eq("cnt_sat", 32'(err_count), 32'd255);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    apply_reset();
    repeat (2) send_bit(1'b1);
    check_eq("sb_empty_end", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/even_parity_checker.md
# even_parity_checker

Serial receiver and checker for the 16-bit even-parity word format, where the parity bit makes the total count of ones across data plus parity even. The block deserialises one framed word per transfer (start, 16 data bits LSB first, parity, stop) at one bit per clock. For each frame it presents the data word, a parity verdict and a framing verdict, and keeps a saturating error count. It sits at the receive end of a serial link, opposite the even-parity generator.

## Interface
- DATA_WIDTH, 16, data bits per frame
- CNT_WIDTH, 8, width of the error counter
- clock  input  1  single system clock; all state changes on posedge
- reset  input  1  synchronous, active-high reset
- serial_in  input  1  serial line; idle level 1
- data_out  output  DATA_WIDTH  last received data word, held until the next frame completes
- valid  output  1  one-cycle pulse: a frame has completed and the outputs were updated
- parity_ok  output  1  1 when data_out plus its parity bit hold an even number of ones
- frame_err  output  1  1 when the stop bit of the last frame sampled 0
- err_count  output  CNT_WIDTH  frames with a parity error or a framing error; saturates at all-ones
- busy  output  1  1 while in any state other than IDLE

## Operation
- States:
  - IDLE: wait for the start bit.
  - DATA: shift in DATA_WIDTH bits.
  - PARITY: sample the parity bit.
  - STOP: sample the stop bit.
  - BREAK: wait for the line to return high after a framing error.
- IDLE -> DATA when serial_in == 0 is sampled. This sample is the start bit.
- DATA:
  - Each cycle shifts serial_in into the shift register, LSB first: the first data bit received lands in data bit 0.
  - A running XOR accumulator, cleared on leaving IDLE, XORs in each data bit.
  - A bit counter runs 0 to DATA_WIDTH-1; after bit DATA_WIDTH-1 is sampled -> PARITY.
- PARITY: XOR serial_in into the accumulator -> STOP.
- STOP:
  - Latch data_out from the shift register.
  - parity_ok = ~accumulator.
  - frame_err = ~serial_in.
  - Assert valid on the next cycle.
  - Next state is IDLE if serial_in == 1, else BREAK.
- BREAK -> IDLE on the first sampled serial_in == 1. A low line in BREAK is never taken as a start bit.
- err_count increments by exactly 1 per frame when (!parity_ok || frame_err), even when both errors occur. It holds at 2^CNT_WIDTH-1.
- A parity error does not discard data: data_out is updated on every completed frame.

## Timing
- Reset values, applied at the clocked edge with reset high:
  - state = IDLE, bit counter = 0, accumulator = 0.
  - data_out = 0, valid = 0, parity_ok = 1, frame_err = 0, err_count = 0, busy = 0.
- Frame timing, with the start bit sampled at edge t:
  - Data bits are sampled at edges t+1 .. t+16.
  - The parity bit is sampled at t+17.
  - The stop bit is sampled at t+18.
  - data_out, parity_ok, frame_err, err_count and valid update at t+18.
  - valid is high for the single cycle following t+18.
- Back-to-back frames: a start bit may be sampled at t+19, immediately after a good stop bit. There are no dead cycles.
- valid is never asserted for two consecutive cycles.
- busy is high from t+1 through t+18, and through all BREAK cycles.
- Reset mid-frame:
  - The partial frame is discarded.
  - No valid pulse.
  - err_count is cleared.
  - The next start bit is accepted the cycle after reset deasserts.
- Reset has priority over every other event in the same cycle.
- A glitch or low level on serial_in in DATA or PARITY is treated as data; there is no mid-frame start detection.

## Test plan
- Frame 0x0007 (three ones) with parity 1 and stop 1 -> one valid pulse at t+19; data_out=0x0007, parity_ok=1, frame_err=0, err_count=0.
- Frame 0x0007 with parity 0 -> data_out=0x0007, parity_ok=0, err_count=1. Then frame 0x0003 with parity 0 -> parity_ok=1, err_count stays 1.
- Frame 0xA5A5 with correct parity 0 and stop bit 0, line held low 5 more cycles then high -> frame_err=1, err_count+1. busy stays high through BREAK, and no new frame starts until the line goes high. A following good frame 0x1234 (parity 1) is received correctly.
- Two frames back-to-back, 0xFFFF (parity 0) then 0x8001 (parity 0), with start bit 2 at t+19 -> valid pulses at t+19 and t+38, both with parity_ok=1.
- Reset asserted at data bit 8 of a frame -> no valid pulse and all outputs at reset values. A frame 0x00FF (parity 0) sent right after reset deasserts is received with parity_ok=1.
- 260 consecutive frames with a parity error -> err_count reaches 255 and stays at 255. A subsequent reset returns it to 0.
